// File: rtl/fslcd_pkg.sv
// Shared types and helpers for the RGB666 LCD capture path.
package fslcd_pkg;

  localparam int RGB888_W = 24;
  // FIFO entry: {pixel, sof, eol}
  localparam int FIFO_W = RGB888_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    DROP
  } state_t;

  // Widen a 6-bit colour by replicating its top bits, so full scale maps to full scale.
  function automatic logic [7:0] expand6to8(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/fslcd_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted when a read
// happens in the same cycle.
module fslcd_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fslcd_capture.sv
// RGB666 parallel LCD receiver producing a 24-bit AXI4-Stream video stream
// with frame sync, elastic buffering and line/frame geometry checking.
module fslcd_capture
  import fslcd_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                de,
  input  logic [5:0]          r,
  input  logic [5:0]          g,
  input  logic [5:0]          b,
  input  logic                hsync,
  input  logic                vsync,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [RGB888_W-1:0] m_axis_tdata,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  input  logic                status_clr,
  output logic                overflow,
  output logic                line_err,
  output logic                frame_err
);

  localparam int PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);

  state_t              state;
  state_t              state_next;
  logic                de_a;
  logic                de_d;
  logic                vs_a;
  logic                vs_d;
  logic                hs_a;
  logic [5:0]          r_a;
  logic [5:0]          g_a;
  logic [5:0]          b_a;
  logic                vs_edge;
  logic                capture_ok;
  logic [RGB888_W-1:0] pix_b;
  logic                sof_b;
  logic                valid_b;
  logic [FIFO_W-1:0]   fifo_din;
  logic [FIFO_W-1:0]   fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_rd;
  logic                drop;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic                line_err_set;
  logic                frame_err_set;
  logic                unused_sigs;

  // hsync is sampled alongside the other pins but framing relies on DE and vsync only.
  assign unused_sigs = &{1'b0, hs_a};

  // Stage A: sample all pins; vsync is normalised so 1 always means active.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      de_a <= 1'b0;
      de_d <= 1'b0;
      vs_a <= 1'b0;
      vs_d <= 1'b0;
      hs_a <= 1'b0;
      r_a  <= '0;
      g_a  <= '0;
      b_a  <= '0;
    end else begin
      de_a <= de;
      de_d <= de_a;
      vs_a <= (vsync == VSYNC_POL);
      vs_d <= vs_a;
      hs_a <= hsync;
      r_a  <= r;
      g_a  <= g;
      b_a  <= b;
    end
  end

  assign vs_edge    = vs_a && !vs_d;
  assign capture_ok = (state == ARMED) || (state == ACTIVE);

  // Stage B: hold one pixel until the next DE sample tells us whether it ends the line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_b   <= '0;
      sof_b   <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_b <= de_a && capture_ok;
      if (de_a && capture_ok) begin
        pix_b <= {expand6to8(r_a), expand6to8(g_a), expand6to8(b_a)};
        sof_b <= (state == ARMED);
      end
    end
  end

  assign fifo_din = {pix_b, sof_b, !de_a};
  assign fifo_rd  = m_axis_tready && !fifo_empty;
  assign drop     = valid_b && fifo_full && !fifo_rd;

  fslcd_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (valid_b),
    .wr_data(fifo_din),
    .rd_en  (fifo_rd),
    .rd_data(fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Frame-sync state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state: vsync re-arms from anywhere; an overflow abandons the rest of the frame.
  always_comb begin
    state_next = state;
    if (vs_edge) begin
      state_next = ARMED;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ARMED:   if (de_a) state_next = ACTIVE;
        ACTIVE:  if (drop) state_next = DROP;
        DROP:    state_next = DROP;
        default: state_next = IDLE;
      endcase
    end
  end

  assign line_err_set  = capture_ok && !vs_edge && !de_a && de_d &&
                         (pix_cnt != PIX_W'(H_ACTIVE));
  assign frame_err_set = vs_edge && (state == ACTIVE) && (line_cnt != LINE_W'(V_ACTIVE));

  // Geometry counters, saturating so a runaway source cannot wrap back to a legal count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (vs_edge) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (capture_ok) begin
      if (de_a) begin
        if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
      end else if (de_d) begin
        pix_cnt <= '0;
        if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)               overflow  <= 1'b1;
      else if (status_clr)    overflow  <= 1'b0;
      if (line_err_set)       line_err  <= 1'b1;
      else if (status_clr)    line_err  <= 1'b0;
      if (frame_err_set)      frame_err <= 1'b1;
      else if (status_clr)    frame_err <= 1'b0;
    end
  end

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[FIFO_W-1:2];
  assign m_axis_tuser  = !fifo_empty && fifo_dout[1];
  assign m_axis_tlast  = !fifo_empty && fifo_dout[0];

endmodule
